// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard beside decode: timed latencies count down,
// unknown-latency entries wait for an explicit writeback; produces a combinational stall.
module reg_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned CNT_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                use_rs,
    input  logic [ADDR_W-1:0]   issue_rs_addr,
    input  logic                use_rt,
    input  logic [ADDR_W-1:0]   issue_rt_addr,
    input  logic                issue_we,
    input  logic [ADDR_W-1:0]   issue_waddr,
    input  logic [CNT_W-1:0]    issue_lat,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic                flush,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                wb_err
);

    localparam logic [CNT_W-1:0] LAT_WB = '1;

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic [CNT_W-1:0] rs_cnt;
    logic [CNT_W-1:0] rt_cnt;
    logic [CNT_W-1:0] wa_cnt;
    logic [CNT_W-1:0] wb_cnt;
    logic             rs_haz;
    logic             rt_haz;
    logic             waw_haz;
    logic             issue_fire;
    logic             wb_err_d;

    // Counter lookups; register 0 and out-of-range addresses read as idle.
    always_comb begin
        rs_cnt = '0;
        rt_cnt = '0;
        wa_cnt = '0;
        wb_cnt = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (issue_rs_addr == ADDR_W'(r)) rs_cnt = cnt_q[r];
            if (issue_rt_addr == ADDR_W'(r)) rt_cnt = cnt_q[r];
            if (issue_waddr   == ADDR_W'(r)) wa_cnt = cnt_q[r];
            if (wb_addr       == ADDR_W'(r)) wb_cnt = cnt_q[r];
        end
    end

    assign rs_haz     = use_rs & (rs_cnt != '0);
    assign rt_haz     = use_rt & (rt_cnt != '0);
    assign waw_haz    = issue_we & (wa_cnt == LAT_WB);
    assign stall      = issue_valid & (rs_haz | rt_haz | waw_haz);
    assign issue_fire = issue_valid & ~stall & issue_we & (issue_waddr != '0);
    assign wb_err_d   = wb_valid & ((wb_addr == '0) | (wb_cnt != LAT_WB)) & ~flush;

    // Next-state per register: flush, then issue, then writeback, then countdown.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0 || flush) begin
                cnt_d[r] = '0;
            end else if (issue_fire && issue_waddr == ADDR_W'(r)) begin
                cnt_d[r] = issue_lat;
            end else if (wb_valid && wb_addr == ADDR_W'(r) && cnt_q[r] == LAT_WB) begin
                cnt_d[r] = '0;
            end else if (cnt_q[r] != '0 && cnt_q[r] != LAT_WB) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            wb_err <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
            wb_err <= wb_err_d;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) busy_vec[r] = (cnt_q[r] != '0);
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hand-computed stall, busy_vec and wb_err
// expectations for timed, unknown-latency, collision and flush scenarios.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        use_rs;
    logic [4:0]  issue_rs_addr;
    logic        use_rt;
    logic [4:0]  issue_rt_addr;
    logic        issue_we;
    logic [4:0]  issue_waddr;
    logic [2:0]  issue_lat;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush;
    logic        stall;
    logic [31:0] busy_vec;
    logic        wb_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .use_rs        (use_rs),
        .issue_rs_addr (issue_rs_addr),
        .use_rt        (use_rt),
        .issue_rt_addr (issue_rt_addr),
        .issue_we      (issue_we),
        .issue_waddr   (issue_waddr),
        .issue_lat     (issue_lat),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .flush         (flush),
        .stall         (stall),
        .busy_vec      (busy_vec),
        .wb_err        (wb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid   = 1'b0;
        use_rs        = 1'b0;
        issue_rs_addr = 5'd0;
        use_rt        = 1'b0;
        issue_rt_addr = 5'd0;
        issue_we      = 1'b0;
        issue_waddr   = 5'd0;
        issue_lat     = 3'd0;
    endtask

    task automatic present(input logic urs, input logic [4:0] rs, input logic urt,
                           input logic [4:0] rt, input logic we, input logic [4:0] wa,
                           input logic [2:0] lat);
        issue_valid   = 1'b1;
        use_rs        = urs;
        issue_rs_addr = rs;
        use_rt        = urt;
        issue_rt_addr = rt;
        issue_we      = we;
        issue_waddr   = wa;
        issue_lat     = lat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst      = 1'b1;
        flush    = 1'b0;
        wb_valid = 1'b0;
        wb_addr  = 5'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and a harmless instruction
        chk("reset_busy", busy_vec, 32'h0);
        chk("reset_wb_err", 32'(wb_err), 32'h0);
        present(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0);
        #1 chk("reset_stall", 32'(stall), 32'h0);

        // Reset while r5 is pending
        present(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 3'd3);
        tick();
        idle();
        chk("r5_busy", busy_vec, 32'h0000_0020);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", busy_vec, 32'h0);

        // Load-use: exactly one bubble
        present(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 3'd1);
        tick();
        present(1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0);
        #1 chk("lu_stall_t1", 32'(stall), 32'h1);
        chk("lu_busy_t1", busy_vec, 32'h0000_0100);
        tick();
        chk("lu_stall_t2", 32'(stall), 32'h0);
        chk("lu_busy_t2", busy_vec, 32'h0);

        // Timed latency 3 on r9; r0 readers never stall
        present(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 3'd3);
        tick();
        for (int i = 1; i <= 3; i++) begin
            present(1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 3'd0);
            #1 chk($sformatf("l3_stall_t%0d", i), 32'(stall), 32'h1);
            present(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 3'd0);
            #1 chk($sformatf("r0_stall_t%0d", i), 32'(stall), 32'h0);
            tick();
        end
        present(1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 3'd0);
        #1 chk("l3_stall_t4", 32'(stall), 32'h0);

        // Latency 0 is untracked
        present(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12, 3'd0);
        tick();
        present(1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0);
        #1 chk("l0_stall", 32'(stall), 32'h0);
        chk("l0_busy", busy_vec, 32'h0);

        // Unknown latency on r10
        present(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 3'd7);
        tick();
        for (int i = 0; i < 20; i++) begin
            present(1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0);
            #1 chk($sformatf("wb_hold_stall_%0d", i), 32'(stall), 32'h1);
            chk($sformatf("wb_hold_busy_%0d", i), busy_vec, 32'h0000_0400);
            tick();
        end
        issue_valid = 1'b0;
        #1 chk("novalid_stall", 32'(stall), 32'h0);
        present(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 3'd7);
        #1 chk("waw_stall", 32'(stall), 32'h1);
        tick();
        chk("waw_busy", busy_vec, 32'h0000_0400);
        present(1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0);
        wb_valid = 1'b1;
        wb_addr  = 5'd10;
        #1 chk("wb_same_cycle_stall", 32'(stall), 32'h1);
        tick();
        wb_valid = 1'b0;
        #1 chk("wb_after_stall", 32'(stall), 32'h0);
        chk("wb_after_busy", busy_vec, 32'h0);
        chk("wb_after_err", 32'(wb_err), 32'h0);

        // Writer of an unknown-latency register meets its writeback: WAW holds it back
        present(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 3'd7);
        tick();
        present(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 3'd2);
        wb_valid = 1'b1;
        wb_addr  = 5'd4;
        #1 chk("sim_waw_stall", 32'(stall), 32'h1);
        tick();
        wb_valid = 1'b0;
        chk("sim_busy", busy_vec, 32'h0);
        chk("sim_wb_err", 32'(wb_err), 32'h0);
        #1 chk("sim_replay_stall", 32'(stall), 32'h0);
        tick();
        chk("sim_replay_busy", busy_vec, 32'h0000_0010);
        // Re-issue over a counting entry reloads instead of decrementing
        tick();
        idle();
        tick();
        chk("issue_beats_dec_busy", busy_vec, 32'h0000_0010);
        tick();
        chk("issue_beats_dec_done", busy_vec, 32'h0);

        // Unmatched writeback to idle r6
        wb_valid = 1'b1;
        wb_addr  = 5'd6;
        tick();
        wb_valid = 1'b0;
        chk("wb_idle_err", 32'(wb_err), 32'h1);
        chk("wb_idle_busy", busy_vec, 32'h0);
        tick();
        chk("wb_idle_err_pulse", 32'(wb_err), 32'h0);

        // Flush with r3 unknown and r11 timed
        present(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 3'd7);
        tick();
        present(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd11, 3'd2);
        tick();
        idle();
        chk("pre_flush_busy", busy_vec, 32'h0000_0808);
        flush    = 1'b1;
        wb_valid = 1'b1;
        wb_addr  = 5'd6;
        tick();
        flush    = 1'b0;
        wb_valid = 1'b0;
        chk("flush_busy", busy_vec, 32'h0);
        chk("flush_masks_err", 32'(wb_err), 32'h0);
        present(1'b1, 5'd3, 1'b1, 5'd11, 1'b0, 5'd0, 3'd0);
        #1 chk("flush_stall", 32'(stall), 32'h0);
        idle();
        wb_valid = 1'b1;
        wb_addr  = 5'd3;
        tick();
        chk("flushed_wb_err", 32'(wb_err), 32'h1);
        wb_addr = 5'd0;
        tick();
        wb_valid = 1'b0;
        chk("wb_r0_err", 32'(wb_err), 32'h1);
        tick();
        chk("final_err", 32'(wb_err), 32'h0);
        chk("final_busy", busy_vec, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
